// File: rtl/sort_stream_engine_if.sv
// Handshake bundle between the serial producer/consumer and the sort stream engine.
// The engine takes the slave view; the producer/consumer side takes the master view.
interface sort_stream_engine_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last,
        output busy
    );
endinterface

// File: rtl/sort_stream_engine.sv
// Serial loader, odd-even transposition sorter and ascending unloader for one batch
// of N unsigned elements: LOAD accepts N beats, SORT runs N passes, DRAIN streams out.
module sort_stream_engine #(
    parameter int WIDTH = 3,
    parameter int N     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sort_stream_engine_if.slave  bus
);
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int            PW       = (N > 2) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

    state_e           state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    pass_q, pass_d;
    logic [WIDTH-1:0] buf_q [N];
    logic [WIDTH-1:0] buf_d [N];

    logic in_fire;
    logic out_fire;

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.busy      = (state_q != LOAD);
    assign bus.out_data  = bus.out_valid ? buf_q[rd_ptr_q] : '0;
    assign bus.out_last  = bus.out_valid && (rd_ptr_q == LAST_IDX);

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    // NOTE: every signal written here gets its default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pass_d   = pass_q;
        buf_d    = buf_q;

        unique case (state_q)
            LOAD: begin
                if (in_fire) begin
                    buf_d[wr_ptr_q] = bus.in_data;
                    if (wr_ptr_q == LAST_IDX) begin
                        wr_ptr_d = '0;
                        pass_d   = '0;
                        state_d  = SORT;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end

            SORT: begin
                // Pairs start on even indices for even passes, odd indices for odd passes;
                // the pairs of one pass are disjoint, so all exchanges happen in parallel.
                for (int i = 0; i < N - 1; i++) begin
                    if ((i % 2) == int'(pass_q[0])) begin
                        if (buf_q[i+1] < buf_q[i]) begin
                            buf_d[i]   = buf_q[i+1];
                            buf_d[i+1] = buf_q[i];
                        end
                    end
                end
                if (pass_q == LAST_IDX) begin
                    rd_ptr_d = '0;
                    state_d  = DRAIN;
                end else begin
                    pass_d = pass_q + 1'b1;
                end
            end

            DRAIN: begin
                if (out_fire) begin
                    if (rd_ptr_q == LAST_IDX) begin
                        rd_ptr_d = '0;
                        state_d  = LOAD;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end

            default: state_d = LOAD;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pass_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pass_q   <= pass_d;
        end
    end

    // NOTE: the element buffer is deliberately not reset; its contents are only read after a full batch is loaded.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end
endmodule

// File: tb/tb_sort_stream_engine.sv
// Randomised scoreboard bench: the driver queues each batch sorted ascending, a negedge
// monitor checks handshakes, latency, busy/in_ready and stall stability against it.
module tb_sort_stream_engine;
    localparam int WIDTH = 3;
    localparam int N     = 8;

    typedef logic [WIDTH-1:0] elem_t;
    typedef elem_t batch_t [N];
    typedef struct {
        elem_t data;
        logic  last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    sort_stream_engine_if #(.WIDTH(WIDTH)) bus ();

    sort_stream_engine #(.WIDTH(WIDTH), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   ready_mode = 0;
    int   drv_cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Consumer readiness, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        drv_cyc++;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ((drv_cyc % 4) == 0) || ((drv_cyc % 4) == 3);
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model: the expected output of a batch is its values sorted ascending.
    task automatic push_expected(input batch_t vals);
        elem_t s[$];
        foreach (vals[i]) s.push_back(vals[i]);
        s.sort();
        foreach (s[i]) exp_q.push_back('{data: s[i], last: (i == N - 1)});
    endtask

    task automatic send_beat(input elem_t v, input int gap);
        repeat (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        for (int g = 0; !bus.in_ready; g++) begin
            if (g > 500) begin
                $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles", g);
                $fatal(1, "engine never returned to load");
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic send_batch(input batch_t vals, input int max_gap, input bit hold);
        push_expected(vals);
        for (int i = 0; i < N; i++) send_beat(vals[i], $urandom_range(0, max_gap));
        if (hold) bus.in_data = elem_t'(7);
        else      bus.in_valid = 1'b0;
    endtask

    // Monitor: protocol model is "busy from last input beat until N outputs taken".
    int    negcnt = 0, beat_cnt = 0, out_cnt = 0, last_k = 0;
    bit    in_batch = 1'b0, prev_stall = 1'b0, started = 1'b0;
    elem_t prev_data;
    logic  prev_last;

    always @(negedge clk) begin
        exp_t e;
        bit   exp_ov;
        negcnt++;
        if (reset) begin
            started    = 1'b1;
            in_batch   = 1'b0;
            beat_cnt   = 0;
            out_cnt    = 0;
            prev_stall = 1'b0;
        end else if (started) begin
            exp_ov = in_batch && ((negcnt - last_k) >= N + 1);
            check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            check("in_ready", 32'(bus.in_ready), 32'(!in_batch));
            check("busy", 32'(bus.busy), 32'(in_batch));
            if (!bus.out_valid) begin
                check("out_data_idle", 32'(bus.out_data), 0);
                check("out_last_idle", 32'(bus.out_last), 0);
            end
            if (prev_stall) begin
                check("stall_data", 32'(bus.out_data), 32'(prev_data));
                check("stall_last", 32'(bus.out_last), 32'(prev_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(bus.out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(e.data));
                    check("out_last", 32'(bus.out_last), 32'(e.last));
                end
                out_cnt++;
                if (out_cnt == N) begin
                    out_cnt  = 0;
                    in_batch = 1'b0;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                beat_cnt++;
                if (beat_cnt == N) begin
                    beat_cnt = 0;
                    in_batch = 1'b1;
                    last_k   = negcnt;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    initial begin
        batch_t b;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Reverse-ordered batch, consumer always ready.
        ready_mode = 0;
        b = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        send_batch(b, 0, 1'b0);

        // Duplicates.
        b = '{3'd3, 3'd3, 3'd0, 3'd7, 3'd3, 3'd0, 3'd7, 3'd1};
        send_batch(b, 0, 1'b0);

        // Stalling consumer 1,0,0,1.
        ready_mode = 1;
        b = '{3'd2, 3'd5, 3'd1, 3'd6, 3'd0, 3'd7, 3'd3, 3'd4};
        send_batch(b, 0, 1'b0);

        // in_valid held with data 7 through SORT/DRAIN; that 7 becomes element 0 next batch.
        ready_mode = 2;
        b = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        send_batch(b, 0, 1'b1);
        b[0] = 3'd7;
        for (int i = 1; i < N; i++) b[i] = elem_t'($urandom_range(0, 7));
        send_batch(b, 0, 1'b0);

        // Reset during pass 3 of SORT discards the batch.
        ready_mode = 0;
        for (int i = 0; i < N; i++) b[i] = elem_t'($urandom_range(0, 7));
        send_batch(b, 0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        b = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
        send_batch(b, 0, 1'b0);

        // Back-to-back: already sorted, then all sevens.
        b = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        send_batch(b, 0, 1'b0);
        b = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
        send_batch(b, 0, 1'b0);

        // Random batches with producer gaps and random consumer stalls.
        ready_mode = 2;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) b[i] = elem_t'($urandom_range(0, 7));
            send_batch(b, 2, 1'b0);
        end

        for (int c = 0; c < 2000 && (exp_q.size() != 0 || in_batch); c++) @(posedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 0);
        check("final_idle", 32'(in_batch), 0);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
